// File: rtl/otter_enc_pkg.sv
// Shared format codes, opcodes and request/response types for the RV32I instruction encoder.
package otter_enc_pkg;

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_J  = 3'd5;
    localparam logic [2:0] FMT_LI = 3'd6;

    localparam logic [6:0] OP_LUI = 7'h37;
    localparam logic [6:0] OP_IMM = 7'h13;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_req_t;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } enc_rsp_t;

endpackage

// File: rtl/otter_imm_pack.sv
// Combinational field packer: range-checks the immediate for the format and builds the word.
module otter_imm_pack
    import otter_enc_pkg::*;
(
    input  enc_req_t req,
    output enc_rsp_t rsp
);

    logic [31:0] imm;
    logic        sx11, sx12, sx20;
    logic [31:0] raw;
    logic        bad;

    assign imm  = req.imm;
    // Sign-extension checks: every bit above the field's sign bit must match it.
    assign sx11 = (imm[31:11] == {21{imm[31]}});
    assign sx12 = (imm[31:12] == {20{imm[31]}});
    assign sx20 = (imm[31:20] == {12{imm[31]}});

    always_comb begin
        raw = NOP_WORD;
        bad = 1'b1;
        case (req.fmt)
            FMT_R: begin
                raw = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
                bad = 1'b0;
            end
            FMT_I: begin
                raw = {imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
                bad = !sx11;
            end
            FMT_S: begin
                raw = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], req.opcode};
                bad = !sx11;
            end
            FMT_B: begin
                raw = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3,
                       imm[4:1], imm[11], req.opcode};
                bad = imm[0] || !sx12;
            end
            FMT_U: begin
                raw = {imm[31:12], req.rd, req.opcode};
                bad = (imm[11:0] != 12'h000);
            end
            FMT_J: begin
                raw = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, req.opcode};
                bad = imm[0] || !sx20;
            end
            default: begin
                raw = NOP_WORD;
                bad = 1'b1;
            end
        endcase
        rsp.word = bad ? NOP_WORD : raw;
        rsp.err  = bad;
    end

endmodule

// File: rtl/otter_instr_encoder.sv
// RV32I field-to-word encoder with a registered valid/ready output and LI -> LUI+ADDI expansion.
module otter_instr_encoder
    import otter_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instrn,
    output logic        out_err,
    output logic        out_last
);

    typedef enum logic {NORMAL, LI_2ND} state_t;

    state_t      state_q, state_d;
    enc_req_t    req0, req1;
    enc_rsp_t    rsp0, rsp1;
    logic [31:0] imm_rnd;
    logic [19:0] hi;
    logic [11:0] lo;
    logic        is_li, two_beat, accept, out_fire;
    logic [31:0] li2_word;

    // hi rounds so that sign-extended lo added back reproduces in_imm exactly.
    assign imm_rnd  = in_imm + 32'h0000_0800;
    assign hi       = imm_rnd[31:12];
    assign lo       = in_imm[11:0];
    assign is_li    = (in_fmt == FMT_LI);
    assign two_beat = is_li && (hi != 20'h0) && (lo != 12'h0);

    assign in_ready = (state_q == NORMAL) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        req0 = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                 funct3: in_funct3, funct7: in_funct7, imm: in_imm};
        if (is_li) begin
            req0.rs2    = 5'd0;
            req0.funct7 = 7'd0;
            req0.funct3 = 3'd0;
            if (hi == 20'h0) begin
                req0.fmt    = FMT_I;
                req0.opcode = OP_IMM;
                req0.rs1    = 5'd0;
                req0.imm    = {{20{lo[11]}}, lo};
            end else begin
                req0.fmt    = FMT_U;
                req0.opcode = OP_LUI;
                req0.rs1    = 5'd0;
                req0.imm    = {hi, 12'h000};
            end
        end
    end

    // Second LI beat: ADDI rd,rd,lo.
    always_comb begin
        req1 = '{fmt: FMT_I, opcode: OP_IMM, rd: in_rd, rs1: in_rd, rs2: 5'd0,
                 funct3: 3'd0, funct7: 7'd0, imm: {{20{lo[11]}}, lo}};
    end

    otter_imm_pack u_pack0 (.req(req0), .rsp(rsp0));
    otter_imm_pack u_pack1 (.req(req1), .rsp(rsp1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL:  if (accept && two_beat) state_d = LI_2ND;
            LI_2ND:  if (out_fire) state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= NORMAL;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_instrn <= 32'h0;
            out_err    <= 1'b0;
            out_last   <= 1'b0;
            li2_word   <= 32'h0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_instrn <= rsp0.word;
            out_err    <= rsp0.err;
            out_last   <= !two_beat;
            if (two_beat) li2_word <= rsp1.word;
        end else if (state_q == LI_2ND && out_fire) begin
            out_valid  <= 1'b1;
            out_instrn <= li2_word;
            out_err    <= 1'b0;
            out_last   <= 1'b1;
        end else if (out_fire) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_otter_instr_encoder.sv
// Directed bench: vector table for single-word encodes plus LI, backpressure, burst and reset sequences.
module tb_otter_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid, out_ready;
    logic [31:0] out_instrn;
    logic        out_err, out_last;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    otter_instr_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instrn(out_instrn),
        .out_err(out_err), .out_last(out_last)
    );

    typedef struct {
        string       name;
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] word;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic [2:0] fmt, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                                input logic [31:0] word, input logic err);
        vec_t v;
        v.name = nm; v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.word = word; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, want %h", nm, got, exp);
        end
    endtask

    task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm);
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    // Called at a negedge with fields set; returns #1 after the accepting posedge.
    task automatic send();
        int waited = 0;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            nvec++; nmis++;
            $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles, want 1", waited);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rword(input logic [4:0] rd);
        return {7'h00, 5'd2, 5'd1, 3'd0, rd, 7'h33};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(mk("b_neg4",    3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'hFFFF_FFFC, 32'hFE20_9EE3, 1'b0));
        vecs.push_back(mk("j_range",   3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 32'h0000_0013, 1'b1));
        vecs.push_back(mk("i_range",   3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0000_0013, 1'b1));
        vecs.push_back(mk("u_lowbits", 3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0001, 32'h0000_0013, 1'b1));
        vecs.push_back(mk("r_sub",     3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF, 32'h4020_81B3, 1'b0));
        vecs.push_back(mk("i_neg1",    3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0));
        vecs.push_back(mk("i_max",     3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_07FF, 32'h7FF0_0093, 1'b0));
        vecs.push_back(mk("s_neg4",    3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFF_FFFC, 32'hFE20_AE23, 1'b0));
        vecs.push_back(mk("u_ok",      3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0));
        vecs.push_back(mk("j_2048",    3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0));
        vecs.push_back(mk("j_odd",     3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0001, 32'h0000_0013, 1'b1));
        vecs.push_back(mk("b_range",   3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'h0000_1000, 32'h0000_0013, 1'b1));
        vecs.push_back(mk("fmt7",      3'd7, 7'h33, 5'd1, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0000, 32'h0000_0013, 1'b1));
        vecs.push_back(mk("li_neg1",   3'd6, 7'h7F, 5'd1, 5'd9, 5'd9, 3'd7, 7'h7F, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0));
        vecs.push_back(mk("li_4k",     3'd6, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1000, 32'h0000_10B7, 1'b0));
        vecs.push_back(mk("li_zero",   3'd6, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0000, 32'h0000_0093, 1'b0));

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_req(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_instrn", out_instrn, 32'd0);
        chk("rst_err", {31'b0, out_err}, 32'd0);
        chk("rst_last", {31'b0, out_last}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);

        foreach (vecs[i]) begin
            @(negedge clk);
            set_req(vecs[i].fmt, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                    vecs[i].f3, vecs[i].f7, vecs[i].imm);
            send();
            @(negedge clk);
            chk({vecs[i].name, "_valid"}, {31'b0, out_valid}, 32'd1);
            chk({vecs[i].name, "_word"}, out_instrn, vecs[i].word);
            chk({vecs[i].name, "_err"}, {31'b0, out_err}, {31'b0, vecs[i].err});
            chk({vecs[i].name, "_last"}, {31'b0, out_last}, 32'd1);
            @(negedge clk);
            chk({vecs[i].name, "_drained"}, {31'b0, out_valid}, 32'd0);
        end

        // LI needing both LUI and ADDI
        @(negedge clk);
        set_req(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5FFF);
        send();
        @(negedge clk);
        chk("li2_lui_word", out_instrn, 32'h1234_62B7);
        chk("li2_lui_last", {31'b0, out_last}, 32'd0);
        chk("li2_ready_low", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        chk("li2_addi_word", out_instrn, 32'hFFF2_8293);
        chk("li2_addi_last", {31'b0, out_last}, 32'd1);
        chk("li2_addi_err", {31'b0, out_err}, 32'd0);
        @(negedge clk);
        chk("li2_drained", {31'b0, out_valid}, 32'd0);

        // Backpressure: A held for 5 cycles while B waits, then swap with no bubble
        @(negedge clk);
        out_ready = 1'b0;
        set_req(3'd0, 7'h33, 5'd10, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
        send();
        set_req(3'd0, 7'h33, 5'd11, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_hold_word", out_instrn, rword(5'd10));
            chk("bp_ready_low", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1 chk("bp_ready_release", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_b_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_b_word", out_instrn, rword(5'd11));
        @(negedge clk);
        chk("bp_drained", {31'b0, out_valid}, 32'd0);

        // 8 back-to-back R-type requests, one word per cycle
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("burst_valid", {31'b0, out_valid}, 32'd1);
                chk("burst_word", out_instrn, rword(5'(k - 1)));
            end
            if (k < 8) begin
                set_req(3'd0, 7'h33, 5'(k), 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
                in_valid = 1'b1;
                #1 chk("burst_ready", {31'b0, in_ready}, 32'd1);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("burst_drained", {31'b0, out_valid}, 32'd0);

        // Reset while the LUI beat is stalled: ADDI beat must be discarded
        @(negedge clk);
        out_ready = 1'b0;
        set_req(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5FFF);
        send();
        @(negedge clk);
        chk("rli_lui_word", out_instrn, 32'h1234_62B7);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rli_valid_cleared", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rli_no_addi", {31'b0, out_valid}, 32'd0);
            chk("rli_ready", {31'b0, in_ready}, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
